// File: rtl/lsu_dcache_arbiter.sv
// lsu_dcache_arbiter
// Serialises the dual-issue load/store slots A and B onto one single-port
// data-cache interface. A pair of slot requests is accepted at once. The
// accesses are made in program order (A, then B), and load results come back
// as per-slot register writebacks in a single response cycle.
//
// Ports
//   clock_i, reset_ni            clock (rising edge), async active-low reset
//   reqValidX_i .. reqWbAddrX_i  slot X (A/B) request: valid, store, address,
//                                store data, load destination register
//   reqReady_o                   1 = the pair presented this cycle is sampled
//   memReq_o .. memWdata_o       cache request: strobe, write, address, data
//   memAck_i, memRdata_i         cache access done this cycle / read data
//   wbEnableX_o .. wbDataX_o     slot X load writeback strobe, register, data
//   done_o                       one-cycle pulse when a transaction completes
//   dbg_state_o                  current FSM state (IDLE=0 ACC_A=1 ACC_B=2 RESP=3)
//
// Handshake: issue presents a pair with reqValidA_i|reqValidB_i. The pair is
// taken on a rising edge where reqReady_o=1. Toward the cache, memReq_o and its
// attributes are held stable until a cycle with memAck_i=1. That edge completes
// the access, and read data is valid in the same cycle.
module lsu_dcache_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int REG_W       = 5,
    parameter int MERGE_LOADS = 1
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              reqValidA_i,
    input  logic              reqStoreA_i,
    input  logic [ADDR_W-1:0] reqAddrA_i,
    input  logic [DATA_W-1:0] reqDataA_i,
    input  logic [REG_W-1:0]  reqWbAddrA_i,
    input  logic              reqValidB_i,
    input  logic              reqStoreB_i,
    input  logic [ADDR_W-1:0] reqAddrB_i,
    input  logic [DATA_W-1:0] reqDataB_i,
    input  logic [REG_W-1:0]  reqWbAddrB_i,
    output logic              reqReady_o,
    output logic              memReq_o,
    output logic              memWe_o,
    output logic [ADDR_W-1:0] memAddr_o,
    output logic [DATA_W-1:0] memWdata_o,
    input  logic              memAck_i,
    input  logic [DATA_W-1:0] memRdata_i,
    output logic              wbEnableA_o,
    output logic [REG_W-1:0]  wbAddressA_o,
    output logic [DATA_W-1:0] wbDataA_o,
    output logic              wbEnableB_o,
    output logic [REG_W-1:0]  wbAddressB_o,
    output logic [DATA_W-1:0] wbDataB_o,
    output logic              done_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_A = 2'd1,
        ACC_B = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched slot attributes
    logic              val_a_q, st_a_q, val_b_q, st_b_q;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q;
    logic [DATA_W-1:0] wdata_a_q, wdata_b_q;
    logic [REG_W-1:0]  wb_addr_a_q, wb_addr_b_q;
    // Load result registers; these also drive the writeback data outputs
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;

    logic accept;
    logic merged;

    assign accept = (state_q == IDLE) && (reqValidA_i || reqValidB_i);

    // Two loads to the same address: the slot A access answers slot B too
    assign merged = (MERGE_LOADS != 0) && val_a_q && val_b_q && !st_a_q && !st_b_q
                    && (addr_a_q == addr_b_q);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            val_a_q     <= 1'b0;
            st_a_q      <= 1'b0;
            addr_a_q    <= '0;
            wdata_a_q   <= '0;
            wb_addr_a_q <= '0;
            rdata_a_q   <= '0;
            val_b_q     <= 1'b0;
            st_b_q      <= 1'b0;
            addr_b_q    <= '0;
            wdata_b_q   <= '0;
            wb_addr_b_q <= '0;
            rdata_b_q   <= '0;
        end else begin
            if (accept) begin
                val_a_q     <= reqValidA_i;
                st_a_q      <= reqStoreA_i;
                addr_a_q    <= reqAddrA_i;
                wdata_a_q   <= reqDataA_i;
                wb_addr_a_q <= reqWbAddrA_i;
                val_b_q     <= reqValidB_i;
                st_b_q      <= reqStoreB_i;
                addr_b_q    <= reqAddrB_i;
                wdata_b_q   <= reqDataB_i;
                wb_addr_b_q <= reqWbAddrB_i;
            end
            if (state_q == ACC_A && memAck_i && !st_a_q) begin
                rdata_a_q <= memRdata_i;
                if (merged) begin
                    rdata_b_q <= memRdata_i;
                end
            end
            if (state_q == ACC_B && memAck_i && !st_b_q) begin
                rdata_b_q <= memRdata_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        reqReady_o  = 1'b0;
        memReq_o    = 1'b0;
        memWe_o     = 1'b0;
        memAddr_o   = '0;
        memWdata_o  = '0;
        wbEnableA_o = 1'b0;
        wbEnableB_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                reqReady_o = 1'b1;
                if (accept) begin
                    state_d = reqValidA_i ? ACC_A : ACC_B;
                end
            end
            ACC_A: begin
                memReq_o   = 1'b1;
                memWe_o    = st_a_q;
                memAddr_o  = addr_a_q;
                memWdata_o = wdata_a_q;
                if (memAck_i) begin
                    state_d = (val_b_q && !merged) ? ACC_B : RESP;
                end
            end
            ACC_B: begin
                memReq_o   = 1'b1;
                memWe_o    = st_b_q;
                memAddr_o  = addr_b_q;
                memWdata_o = wdata_b_q;
                if (memAck_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                done_o      = 1'b1;
                wbEnableA_o = val_a_q && !st_a_q;
                wbEnableB_o = val_b_q && !st_b_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wbAddressA_o = wb_addr_a_q;
    assign wbAddressB_o = wb_addr_b_q;
    assign wbDataA_o    = rdata_a_q;
    assign wbDataB_o    = rdata_b_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// Bench for lsu_dcache_arbiter: directed scenarios plus randomized pairs,
// against a cache responder and a sequential memory reference model.
module tb_lsu_dcache_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          va = 0, sa = 0, vb = 0, sb = 0;
    logic [AW-1:0] aa = 0, ab = 0;
    logic [DW-1:0] da = 0, db = 0;
    logic [RW-1:0] wa = 0, wb = 0;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic          req_ready, mem_req, mem_we, wb_en_a, wb_en_b, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, wb_data_a, wb_data_b;
    logic [RW-1:0] wb_addr_a, wb_addr_b;
    logic [1:0]    dbg_state;

    lsu_dcache_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REG_W(RW), .MERGE_LOADS(1)) dut (
        .clock_i(clk), .reset_ni(rst_n),
        .reqValidA_i(va), .reqStoreA_i(sa), .reqAddrA_i(aa), .reqDataA_i(da), .reqWbAddrA_i(wa),
        .reqValidB_i(vb), .reqStoreB_i(sb), .reqAddrB_i(ab), .reqDataB_i(db), .reqWbAddrB_i(wb),
        .reqReady_o(req_ready),
        .memReq_o(mem_req), .memWe_o(mem_we), .memAddr_o(mem_addr), .memWdata_o(mem_wdata),
        .memAck_i(mem_ack), .memRdata_i(mem_rdata),
        .wbEnableA_o(wb_en_a), .wbAddressA_o(wb_addr_a), .wbDataA_o(wb_data_a),
        .wbEnableB_o(wb_en_b), .wbAddressB_o(wb_addr_b), .wbDataB_o(wb_data_b),
        .done_o(done), .dbg_state_o(dbg_state)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- memories: cache contents and reference model ----------------
    logic [DW-1:0] cmem[int];
    logic [DW-1:0] smem[int];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] cread(input logic [AW-1:0] a);
        return cmem.exists(int'(a)) ? cmem[int'(a)] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] sread(input logic [AW-1:0] a);
        return smem.exists(int'(a)) ? smem[int'(a)] : init_val(a);
    endfunction

    // Expected cache accesses in order: {we, addr, wdata (0 for loads)}
    logic [AW+DW:0] exp_q[$];

    // ---------------- cache responder ----------------
    int            force_wait  = -1;  // -1: random wait states 0..3
    int            wait_total  = 0;
    int            ack_count   = 0;
    bit            in_hold     = 0;
    int            wait_left   = 0;
    logic [AW-1:0] hold_addr;
    logic          hold_we;
    logic [DW-1:0] hold_wdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_hold = 0;
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (!in_hold) begin
                in_hold    = 1;
                hold_addr  = mem_addr;
                hold_we    = mem_we;
                hold_wdata = mem_wdata;
                wait_left  = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                wait_total += wait_left;
            end else begin
                check("hold_addr", mem_addr, hold_addr);
                check("hold_we", mem_we, hold_we);
                check("hold_wdata", mem_wdata, hold_wdata);
            end
            if (wait_left == 0) begin
                mem_ack = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_access", 1, 0);
                end else begin
                    check("access", {mem_we, mem_addr, (mem_we ? mem_wdata : {DW{1'b0}})},
                          exp_q.pop_front());
                end
                if (mem_we) begin
                    cmem[int'(mem_addr)] = mem_wdata;
                    mem_rdata = DW'($urandom);
                end else begin
                    mem_rdata = cread(mem_addr);
                end
                in_hold = 0;
                ack_count++;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = DW'($urandom);
                wait_left--;
            end
        end else begin
            // Stray acks while nothing is requested must be ignored
            in_hold   = 0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = DW'($urandom);
        end
    end

    // ---------------- driver ----------------
    logic [DW-1:0] obs_wb_a, obs_wb_b;

    task automatic run_txn(
        input logic ia_v, input logic ia_s, input logic [AW-1:0] ia_a,
        input logic [DW-1:0] ia_d, input logic [RW-1:0] ia_w,
        input logic ib_v, input logic ib_s, input logic [AW-1:0] ib_a,
        input logic [DW-1:0] ib_d, input logic [RW-1:0] ib_w);
        bit            mrg;
        int            n_acc, w0, a0, cyc;
        bit            got;
        logic [DW-1:0] exp_a, exp_b;
        // Reference model: program-order accesses on a flat memory
        mrg   = ia_v && ib_v && !ia_s && !ib_s && (ia_a == ib_a);
        n_acc = 0;
        exp_a = '0;
        exp_b = '0;
        if (ia_v) begin
            exp_q.push_back({ia_s, ia_a, (ia_s ? ia_d : {DW{1'b0}})});
            if (ia_s) smem[int'(ia_a)] = ia_d;
            else exp_a = sread(ia_a);
            n_acc++;
        end
        if (ib_v && !mrg) begin
            exp_q.push_back({ib_s, ib_a, (ib_s ? ib_d : {DW{1'b0}})});
            if (ib_s) smem[int'(ib_a)] = ib_d;
            else exp_b = sread(ib_a);
            n_acc++;
        end
        if (mrg) exp_b = exp_a;

        check("ready_idle", req_ready, 1);
        w0 = wait_total;
        a0 = ack_count;
        va = ia_v; sa = ia_s; aa = ia_a; da = ia_d; wa = ia_w;
        vb = ib_v; sb = ib_s; ab = ib_a; db = ib_d; wb = ib_w;
        @(posedge clk);
        #1;
        va = 0; vb = 0;
        aa = AW'($urandom); ab = AW'($urandom); da = DW'($urandom); db = DW'($urandom);

        if (!ia_v && !ib_v) begin
            @(negedge clk);
            check("none_ready", req_ready, 1);
            check("none_req", mem_req, 0);
            return;
        end

        cyc = 0;
        got = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1;
            else begin
                check("stall_ready", req_ready, 0);
                check("early_wb_en", {wb_en_a, wb_en_b}, 0);
            end
        end
        if (!got) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("latency", cyc, 1 + n_acc + (wait_total - w0));
        check("access_count", ack_count - a0, n_acc);
        check("resp_ready", req_ready, 0);
        check("wb_en_a", wb_en_a, ia_v && !ia_s);
        check("wb_en_b", wb_en_b, ib_v && !ib_s);
        if (ia_v && !ia_s) begin
            check("wb_addr_a", wb_addr_a, ia_w);
            check("wb_data_a", wb_data_a, exp_a);
        end
        if (ib_v && !ib_s) begin
            check("wb_addr_b", wb_addr_b, ib_w);
            check("wb_data_b", wb_data_b, exp_b);
        end
        obs_wb_a = wb_data_a;
        obs_wb_b = wb_data_b;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("ready_after", req_ready, 1);
        check("wb_en_pulse", {wb_en_a, wb_en_b}, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_req", mem_req, 0);
        check("rst_done", done, 0);
        check("rst_wb_en", {wb_en_a, wb_en_b}, 0);
        check("rst_wb_data", {wb_data_a, wb_data_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of an A access
        force_wait = 10;
        va = 1; sa = 0; aa = 16'h0009; wa = 5'd3; vb = 0;
        @(posedge clk);
        #1;
        va = 0;
        @(negedge clk);
        check("mid_req_active", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_ready", req_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_done", done, 0);
            check("mid_rst_no_wb", {wb_en_a, wb_en_b}, 0);
            check("mid_rst_ready_after", req_ready, 1);
        end

        // Single load, zero-wait
        force_wait = 0;
        cmem[3] = 16'hBEEF;
        smem[3] = 16'hBEEF;
        run_txn(1, 0, 16'h0003, 16'h0, 5'd4, 0, 0, 16'h0, 16'h0, 5'd0);
        check("t2_beef", obs_wb_a, 16'hBEEF);

        // Store A then load B at the same address
        run_txn(1, 1, 16'h0005, 16'h1234, 5'd1, 1, 0, 16'h0005, 16'h0, 5'd9);
        check("t3_forward", obs_wb_b, 16'h1234);

        // Merged loads
        run_txn(1, 0, 16'h0007, 16'h0, 5'd2, 1, 0, 16'h0007, 16'h0, 5'd6);
        check("t4_merge_a", obs_wb_a, init_val(16'h0007));
        check("t4_merge_b", obs_wb_b, init_val(16'h0007));

        // Wait states held for three cycles
        force_wait = 3;
        run_txn(1, 1, 16'h0011, 16'hC0DE, 5'd0, 1, 0, 16'h0012, 16'h0, 5'd7);

        // Two stores to the same address, then readback
        force_wait = 0;
        run_txn(1, 1, 16'h0002, 16'hAAAA, 5'd0, 1, 1, 16'h0002, 16'h5555, 5'd0);
        run_txn(1, 0, 16'h0002, 16'h0, 5'd8, 0, 0, 16'h0, 16'h0, 5'd0);
        check("t6_readback", obs_wb_a, 16'h5555);

        // B-only and empty pairs
        run_txn(0, 0, 16'h0, 16'h0, 5'd0, 1, 0, 16'h0002, 16'h0, 5'd11);
        run_txn(0, 0, 16'h0, 16'h0, 5'd0, 0, 0, 16'h0, 16'h0, 5'd0);

        // Randomized pairs over a small address window
        force_wait = -1;
        for (int i = 0; i < 300; i++) begin
            run_txn($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    AW'($urandom_range(0, 7)), DW'($urandom), RW'($urandom_range(0, 31)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    AW'($urandom_range(0, 7)), DW'($urandom), RW'($urandom_range(0, 31)));
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
